// File: rtl/axi_arb_2to1_if.sv
// Bundles both sides of the 2:1 arbiter: packed per-master buses (m_*) and the shared slave channel (s_*).
// The slave modport is the arbiter's view; the master modport is the view of the masters plus the slave.
interface axi_arb_2to1_if #(parameter int IDW = 4);
  logic [63:0]      m_awaddr;
  logic [2*IDW-1:0] m_awid;
  logic [7:0]       m_awlen;
  logic [1:0]       m_awvalid;
  logic [1:0]       m_awready;
  logic [63:0]      m_wdata;
  logic [7:0]       m_wstrb;
  logic [1:0]       m_wlast;
  logic [1:0]       m_wvalid;
  logic [1:0]       m_wready;
  logic [1:0]       m_bvalid;
  logic [1:0]       m_bready;
  logic [IDW-1:0]   m_bid;
  logic [1:0]       m_bresp;
  logic [63:0]      m_araddr;
  logic [2*IDW-1:0] m_arid;
  logic [7:0]       m_arlen;
  logic [1:0]       m_arvalid;
  logic [1:0]       m_arready;
  logic [1:0]       m_rvalid;
  logic [1:0]       m_rready;
  logic [31:0]      m_rdata;
  logic [IDW-1:0]   m_rid;
  logic [1:0]       m_rresp;
  logic             m_rlast;

  logic [31:0]      s_awaddr;
  logic [IDW:0]     s_awid;
  logic [3:0]       s_awlen;
  logic             s_awvalid;
  logic             s_awready;
  logic [31:0]      s_wdata;
  logic [IDW:0]     s_wid;
  logic [3:0]       s_wstrb;
  logic             s_wlast;
  logic             s_wvalid;
  logic             s_wready;
  logic [IDW:0]     s_bid;
  logic [1:0]       s_bresp;
  logic             s_bvalid;
  logic             s_bready;
  logic [31:0]      s_araddr;
  logic [IDW:0]     s_arid;
  logic [3:0]       s_arlen;
  logic             s_arvalid;
  logic             s_arready;
  logic [31:0]      s_rdata;
  logic [IDW:0]     s_rid;
  logic [1:0]       s_rresp;
  logic             s_rlast;
  logic             s_rvalid;
  logic             s_rready;

  modport slave (
    input  m_awaddr, m_awid, m_awlen, m_awvalid,
    output m_awready,
    input  m_wdata, m_wstrb, m_wlast, m_wvalid,
    output m_wready,
    output m_bvalid, m_bid, m_bresp,
    input  m_bready,
    input  m_araddr, m_arid, m_arlen, m_arvalid,
    output m_arready,
    output m_rvalid, m_rdata, m_rid, m_rresp, m_rlast,
    input  m_rready,
    output s_awaddr, s_awid, s_awlen, s_awvalid,
    input  s_awready,
    output s_wdata, s_wid, s_wstrb, s_wlast, s_wvalid,
    input  s_wready,
    input  s_bid, s_bresp, s_bvalid,
    output s_bready,
    output s_araddr, s_arid, s_arlen, s_arvalid,
    input  s_arready,
    input  s_rdata, s_rid, s_rresp, s_rlast, s_rvalid,
    output s_rready
  );

  modport master (
    output m_awaddr, m_awid, m_awlen, m_awvalid,
    input  m_awready,
    output m_wdata, m_wstrb, m_wlast, m_wvalid,
    input  m_wready,
    input  m_bvalid, m_bid, m_bresp,
    output m_bready,
    output m_araddr, m_arid, m_arlen, m_arvalid,
    input  m_arready,
    input  m_rvalid, m_rdata, m_rid, m_rresp, m_rlast,
    output m_rready,
    input  s_awaddr, s_awid, s_awlen, s_awvalid,
    output s_awready,
    input  s_wdata, s_wid, s_wstrb, s_wlast, s_wvalid,
    output s_wready,
    output s_bid, s_bresp, s_bvalid,
    input  s_bready,
    input  s_araddr, s_arid, s_arlen, s_arvalid,
    output s_arready,
    output s_rdata, s_rid, s_rresp, s_rlast, s_rvalid,
    input  s_rready
  );
endinterface

// File: rtl/axi_arb_2to1.sv
// 2:1 round-robin arbiter sharing one AXI3-style slave; independent write and read paths,
// one transaction in flight per direction, zero-latency forwarding once granted.
//
// state  | meaning
// W_IDLE | no write granted; pick winner when any m_awvalid
// W_ADDR | forward AW of master wg
// W_DATA | forward W beats of master wg until wlast
// W_RESP | route B back to master wg
// R_IDLE | no read granted; pick winner when any m_arvalid
// R_ADDR | forward AR of master rg
// R_DATA | route R beats to master rg until rlast
module axi_arb_2to1 #(
  parameter int IDW = 4
) (
  input  logic           clk,
  input  logic           rstn,
  axi_arb_2to1_if.slave  bus
);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

  w_state_t       w_state, w_next;
  r_state_t       r_state, r_next;
  logic           wg, wg_next, wlast_srv, wlast_next;
  logic           rg, rg_next, rlast_srv, rlast_next;
  logic [IDW-1:0] awid_q, awid_next;

  // Slave ID MSB is ignored on responses: routing always follows the registered grant.
  logic unused_id_msb;
  assign unused_id_msb = bus.s_bid[IDW] ^ bus.s_rid[IDW];

  function automatic logic rr_pick(input logic [1:0] req, input logic last);
    if (req == 2'b11) return ~last;
    return req[1];
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state   <= W_IDLE;
      wg        <= 1'b0;
      wlast_srv <= 1'b1;
      awid_q    <= '0;
      r_state   <= R_IDLE;
      rg        <= 1'b0;
      rlast_srv <= 1'b1;
    end else begin
      w_state   <= w_next;
      wg        <= wg_next;
      wlast_srv <= wlast_next;
      awid_q    <= awid_next;
      r_state   <= r_next;
      rg        <= rg_next;
      rlast_srv <= rlast_next;
    end
  end

  always_comb begin
    w_next         = w_state;
    wg_next        = wg;
    wlast_next     = wlast_srv;
    awid_next      = awid_q;
    bus.s_awaddr   = '0;
    bus.s_awid     = '0;
    bus.s_awlen    = '0;
    bus.s_awvalid  = 1'b0;
    bus.m_awready  = '0;
    bus.s_wdata    = '0;
    bus.s_wid      = '0;
    bus.s_wstrb    = '0;
    bus.s_wlast    = 1'b0;
    bus.s_wvalid   = 1'b0;
    bus.m_wready   = '0;
    bus.m_bvalid   = '0;
    bus.s_bready   = 1'b0;
    bus.m_bid      = '0;
    bus.m_bresp    = '0;
    case (w_state)
      W_IDLE: begin
        if (|bus.m_awvalid) begin
          wg_next = rr_pick(bus.m_awvalid, wlast_srv);
          w_next  = W_ADDR;
        end
      end
      W_ADDR: begin
        bus.s_awaddr      = wg ? bus.m_awaddr[63:32] : bus.m_awaddr[31:0];
        bus.s_awid        = {wg, (wg ? bus.m_awid[2*IDW-1:IDW] : bus.m_awid[IDW-1:0])};
        bus.s_awlen       = wg ? bus.m_awlen[7:4] : bus.m_awlen[3:0];
        bus.s_awvalid     = bus.m_awvalid[wg];
        bus.m_awready[wg] = bus.s_awready;
        if (bus.m_awvalid[wg] && bus.s_awready) begin
          awid_next = wg ? bus.m_awid[2*IDW-1:IDW] : bus.m_awid[IDW-1:0];
          w_next    = W_DATA;
        end
      end
      W_DATA: begin
        bus.s_wdata      = wg ? bus.m_wdata[63:32] : bus.m_wdata[31:0];
        bus.s_wid        = {wg, awid_q};
        bus.s_wstrb      = wg ? bus.m_wstrb[7:4] : bus.m_wstrb[3:0];
        bus.s_wlast      = bus.m_wlast[wg];
        bus.s_wvalid     = bus.m_wvalid[wg];
        bus.m_wready[wg] = bus.s_wready;
        if (bus.m_wvalid[wg] && bus.s_wready && bus.m_wlast[wg]) w_next = W_RESP;
      end
      W_RESP: begin
        bus.m_bvalid[wg] = bus.s_bvalid;
        bus.s_bready     = bus.m_bready[wg];
        bus.m_bid        = bus.s_bid[IDW-1:0];
        bus.m_bresp      = bus.s_bresp;
        if (bus.s_bvalid && bus.m_bready[wg]) begin
          w_next     = W_IDLE;
          wlast_next = wg;
        end
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next         = r_state;
    rg_next        = rg;
    rlast_next     = rlast_srv;
    bus.s_araddr   = '0;
    bus.s_arid     = '0;
    bus.s_arlen    = '0;
    bus.s_arvalid  = 1'b0;
    bus.m_arready  = '0;
    bus.m_rvalid   = '0;
    bus.s_rready   = 1'b0;
    bus.m_rdata    = '0;
    bus.m_rid      = '0;
    bus.m_rresp    = '0;
    bus.m_rlast    = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (|bus.m_arvalid) begin
          rg_next = rr_pick(bus.m_arvalid, rlast_srv);
          r_next  = R_ADDR;
        end
      end
      R_ADDR: begin
        bus.s_araddr      = rg ? bus.m_araddr[63:32] : bus.m_araddr[31:0];
        bus.s_arid        = {rg, (rg ? bus.m_arid[2*IDW-1:IDW] : bus.m_arid[IDW-1:0])};
        bus.s_arlen       = rg ? bus.m_arlen[7:4] : bus.m_arlen[3:0];
        bus.s_arvalid     = bus.m_arvalid[rg];
        bus.m_arready[rg] = bus.s_arready;
        if (bus.m_arvalid[rg] && bus.s_arready) r_next = R_DATA;
      end
      R_DATA: begin
        bus.m_rvalid[rg] = bus.s_rvalid;
        bus.s_rready     = bus.m_rready[rg];
        bus.m_rdata      = bus.s_rdata;
        bus.m_rid        = bus.s_rid[IDW-1:0];
        bus.m_rresp      = bus.s_rresp;
        bus.m_rlast      = bus.s_rlast;
        if (bus.s_rvalid && bus.m_rready[rg] && bus.s_rlast) begin
          r_next     = R_IDLE;
          rlast_next = rg;
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_arb_2to1.sv
// Directed bench for axi_arb_2to1: the bench plays both masters and the slave,
// driving on the falling edge and checking combinational outputs 1ns later.
module tb_axi_arb_2to1;
  localparam int IDW = 4;

  logic clk;
  logic rstn;
  int   n_cmp;
  int   n_err;

  axi_arb_2to1_if #(.IDW(IDW)) bus ();

  axi_arb_2to1 #(.IDW(IDW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] wd(input int m, input int b);
    return 32'hA000_0000 | (m << 8) | b;
  endfunction

  function automatic logic [31:0] rd(input int b);
    return 32'hD000_0000 + b;
  endfunction

  task automatic clear_inputs();
    bus.m_awvalid = '0; bus.m_wvalid = '0; bus.m_wlast = '0; bus.m_bready = '0;
    bus.m_arvalid = '0; bus.m_rready = '0;
    bus.s_awready = 1'b0; bus.s_wready = 1'b0; bus.s_bvalid = 1'b0; bus.s_bid = '0; bus.s_bresp = '0;
    bus.s_arready = 1'b0; bus.s_rvalid = 1'b0; bus.s_rdata = '0; bus.s_rid = '0;
    bus.s_rresp = '0; bus.s_rlast = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // Caller raises m_awvalid[m]; M0 uses addr 0x100 id 3, M1 addr 0x200 id 5.
  task automatic wr_serve(input int m, input int len);
    int t;
    logic [31:0] addr;
    logic [3:0]  id;
    addr = (m == 1) ? 32'h0000_0200 : 32'h0000_0100;
    id   = (m == 1) ? 4'h5 : 4'h3;
    bus.m_awlen[m*4 +: 4] = len[3:0];
    t = 0;
    #1;
    while (!bus.s_awvalid && t < 20) begin @(negedge clk); #1; t++; end
    chk("aw_valid", bus.s_awvalid, 1);
    chk("aw_grant", bus.s_awid[IDW], m);
    chk("aw_id", bus.s_awid[IDW-1:0], id);
    chk("aw_addr", bus.s_awaddr, addr);
    chk("aw_len", bus.s_awlen, len);
    chk("aw_rdy_hold", bus.m_awready, 0);
    bus.s_awready = 1'b1;
    #1;
    chk("aw_rdy", bus.m_awready, 2'b01 << m);
    @(negedge clk);
    bus.m_awvalid[m] = 1'b0;
    bus.s_awready    = 1'b0;
    for (int b = 0; b <= len; b++) begin
      bus.m_wdata[m*32 +: 32] = wd(m, b);
      bus.m_wlast[m]  = (b == len);
      bus.m_wvalid[m] = 1'b1;
      bus.s_wready    = 1'b1;
      #1;
      chk("w_data", bus.s_wdata, wd(m, b));
      chk("w_id", bus.s_wid, {m[0], id});
      chk("w_strb", bus.s_wstrb, (m == 1) ? 4'hC : 4'hF);
      chk("w_last", bus.s_wlast, (b == len));
      chk("w_rdy", bus.m_wready, 2'b01 << m);
      @(negedge clk);
    end
    bus.m_wvalid[m] = 1'b0;
    bus.m_wlast[m]  = 1'b0;
    bus.s_wready    = 1'b0;
    bus.s_bvalid    = 1'b1;
    bus.s_bid       = {m[0], id};
    bus.s_bresp     = 2'b01;
    bus.m_bready[m] = 1'b1;
    #1;
    chk("b_valid", bus.m_bvalid, 2'b01 << m);
    chk("b_id", bus.m_bid, id);
    chk("b_resp", bus.m_bresp, 2'b01);
    chk("b_rdy", bus.s_bready, 1);
    @(negedge clk);
    bus.s_bvalid    = 1'b0;
    bus.s_bid       = '0;
    bus.m_bready[m] = 1'b0;
    #1;
    chk("b_done", bus.m_bvalid, 0);
  endtask

  // Caller raises m_arvalid[m]; M0 uses addr 0x400 id 6, M1 addr 0x800 id 9. stall<0 means none.
  task automatic rd_serve(input int m, input int len, input int stall);
    int t;
    logic [31:0] addr;
    logic [3:0]  id;
    addr = (m == 1) ? 32'h0000_0800 : 32'h0000_0400;
    id   = (m == 1) ? 4'h9 : 4'h6;
    bus.m_arlen[m*4 +: 4] = len[3:0];
    t = 0;
    #1;
    while (!bus.s_arvalid && t < 20) begin @(negedge clk); #1; t++; end
    chk("ar_valid", bus.s_arvalid, 1);
    chk("ar_grant", bus.s_arid[IDW], m);
    chk("ar_id", bus.s_arid[IDW-1:0], id);
    chk("ar_addr", bus.s_araddr, addr);
    chk("ar_len", bus.s_arlen, len);
    bus.s_arready = 1'b1;
    #1;
    chk("ar_rdy", bus.m_arready, 2'b01 << m);
    @(negedge clk);
    bus.m_arvalid[m] = 1'b0;
    bus.s_arready    = 1'b0;
    for (int b = 0; b <= len; b++) begin
      bus.s_rvalid = 1'b1;
      bus.s_rdata  = rd(b);
      bus.s_rid    = {m[0], id};
      bus.s_rresp  = 2'b00;
      bus.s_rlast  = (b == len);
      if (b == stall) begin
        bus.m_rready[m] = 1'b0;
        repeat (3) begin
          #1;
          chk("r_hold", bus.m_rdata, rd(b));
          chk("r_stall_rdy", bus.s_rready, 0);
          @(negedge clk);
        end
      end
      bus.m_rready[m] = 1'b1;
      #1;
      chk("r_valid", bus.m_rvalid, 2'b01 << m);
      chk("r_data", bus.m_rdata, rd(b));
      chk("r_id", bus.m_rid, id);
      chk("r_last", bus.m_rlast, (b == len));
      chk("r_rdy", bus.s_rready, 1);
      @(negedge clk);
    end
    bus.s_rvalid    = 1'b0;
    bus.s_rlast     = 1'b0;
    bus.m_rready[m] = 1'b0;
    #1;
    chk("r_done", bus.m_rvalid, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    n_cmp = 0;
    n_err = 0;
    rstn  = 1'b0;
    clear_inputs();
    bus.m_awaddr = {32'h0000_0200, 32'h0000_0100};
    bus.m_awid   = {4'h5, 4'h3};
    bus.m_awlen  = '0;
    bus.m_wdata  = '0;
    bus.m_wstrb  = {4'hC, 4'hF};
    bus.m_araddr = {32'h0000_0800, 32'h0000_0400};
    bus.m_arid   = {4'h9, 4'h6};
    bus.m_arlen  = '0;

    // Requests held during reset must not leak through.
    bus.m_awvalid = 2'b11;
    bus.m_arvalid = 2'b11;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_awvalid", bus.s_awvalid, 0);
    chk("rst_arvalid", bus.s_arvalid, 0);
    chk("rst_awready", bus.m_awready, 0);
    chk("rst_arready", bus.m_arready, 0);
    chk("rst_wready", bus.m_wready, 0);
    chk("rst_bvalid", bus.m_bvalid, 0);
    chk("rst_rvalid", bus.m_rvalid, 0);
    chk("rst_bready", bus.s_bready, 0);
    chk("rst_rready", bus.s_rready, 0);
    chk("rst_awaddr", bus.s_awaddr, 0);
    do_reset();

    // M0 alone, len 3
    bus.m_awvalid[0] = 1'b1;
    wr_serve(0, 3);

    // Both AW after reset: M0 first, M1 held
    do_reset();
    bus.m_awvalid = 2'b11;
    wr_serve(0, 3);
    wr_serve(1, 1);

    // Six back-to-back writes alternate starting with M0
    do_reset();
    bus.m_awvalid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      wr_serve(k % 2, k % 3);
      bus.m_awvalid[k % 2] = 1'b1;
    end
    bus.m_awvalid = '0;

    // Concurrent M1 read len 7 and M0 write len 0
    do_reset();
    fork
      begin
        bus.m_awvalid[0] = 1'b1;
        wr_serve(0, 0);
      end
      begin
        bus.m_arvalid[1] = 1'b1;
        rd_serve(1, 7, -1);
      end
    join

    // Read backpressure on beat 1
    @(negedge clk);
    bus.m_arvalid[0] = 1'b1;
    rd_serve(0, 2, 1);

    // Reset during W_DATA beat 2
    do_reset();
    bus.m_awlen[3:0] = 4'd3;
    bus.m_awvalid[0] = 1'b1;
    t = 0;
    #1;
    while (!bus.s_awvalid && t < 20) begin @(negedge clk); #1; t++; end
    chk("rst_mid_aw", bus.s_awvalid, 1);
    bus.s_awready = 1'b1;
    @(negedge clk);
    bus.m_awvalid[0] = 1'b0;
    bus.s_awready    = 1'b0;
    for (int b = 0; b < 3; b++) begin
      bus.m_wdata[31:0] = wd(0, b);
      bus.m_wvalid[0]   = 1'b1;
      bus.s_wready      = 1'b1;
      if (b < 2) @(negedge clk);
    end
    #1;
    chk("rst_mid_pre", bus.s_wvalid, 1);
    rstn = 1'b0;
    #1;
    chk("rst_mid_wvalid", bus.s_wvalid, 0);
    chk("rst_mid_wready", bus.m_wready, 0);
    chk("rst_mid_wdata", bus.s_wdata, 0);
    @(negedge clk);
    #1;
    chk("rst_mid_hold", bus.s_wvalid, 0);
    clear_inputs();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    bus.m_awvalid = 2'b11;
    wr_serve(0, 2);
    wr_serve(1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
